// File: rtl/mem_bridge.sv
// mem_bridge: turns one core memory access into one request/grant/response bus
// transaction, with byte-lane steering, load extension, alignment check and timeout.
module mem_bridge #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned ADDR_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [4:0]        mem_ctrl,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_din,
  output logic [31:0]       mem_dout,
  output logic              mem_ready,
  output logic              mem_err,
  output logic              bus_req,
  output logic              bus_we,
  output logic [3:0]        bus_be,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [31:0]       bus_wdata,
  input  logic              bus_gnt,
  input  logic              bus_rvalid,
  input  logic [31:0]       bus_rdata
);

  // One spare count value so the counter can hold TIMEOUT itself.
  localparam int unsigned CntW = $clog2(TIMEOUT + 2);

  typedef enum logic [1:0] {StIdle, StReq, StWait, StDone} state_e;

  state_e            state_q, state_d;
  logic [3:0]        ctrl_q, ctrl_d;  // {we, uns, size[1:0]}
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       din_q, din_d;
  logic [31:0]       dout_q, dout_d;
  logic              err_q, err_d;
  logic [CntW-1:0]   cnt_q, cnt_d;

  logic              in_bad;
  logic              expired;
  logic [1:0]        off;
  logic [3:0]        be;
  logic [31:0]       wdata;
  logic [31:0]       shifted;
  logic [31:0]       load_val;

  // Alignment / size check of the access presented in IDLE.
  always_comb begin
    case (mem_ctrl[1:0])
      2'd0:    in_bad = 1'b0;
      2'd1:    in_bad = mem_addr[0];
      2'd2:    in_bad = |mem_addr[1:0];
      default: in_bad = 1'b1;
    endcase
  end

  // Lane steering for stores and extraction/extension for loads, from latched access.
  always_comb begin
    off      = addr_q[1:0];
    shifted  = bus_rdata >> {off, 3'b000};
    be       = 4'b1111;
    wdata    = din_q;
    load_val = bus_rdata;
    case (ctrl_q[1:0])
      2'd0: begin
        be       = 4'b0001 << off;
        wdata    = {4{din_q[7:0]}};
        load_val = ctrl_q[2] ? {24'h0, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
      end
      2'd1: begin
        be       = 4'b0011 << off;
        wdata    = {2{din_q[15:0]}};
        load_val = ctrl_q[2] ? {16'h0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
      end
      default: ;
    endcase
  end

  // Timeout fires on the TIMEOUT-th cycle spent in REQ/WAIT; it wins over gnt/rvalid.
  assign expired = (TIMEOUT != 0) && (cnt_q == CntW'(TIMEOUT - 1));

  // Next-state logic and access latching.
  always_comb begin
    state_d = state_q;
    ctrl_d  = ctrl_q;
    addr_d  = addr_q;
    din_d   = din_q;
    dout_d  = dout_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        dout_d = '0;
        err_d  = 1'b0;
        if (mem_ctrl[4]) begin
          ctrl_d = mem_ctrl[3:0];
          addr_d = mem_addr;
          din_d  = mem_din;
          cnt_d  = '0;
          if (in_bad) begin
            err_d   = 1'b1;
            state_d = StDone;
          end else begin
            state_d = StReq;
          end
        end
      end
      StReq: begin
        cnt_d = cnt_q + CntW'(1);
        if (expired) begin
          err_d   = 1'b1;
          dout_d  = '0;
          state_d = StDone;
        end else if (bus_gnt) begin
          state_d = StWait;
        end
      end
      StWait: begin
        cnt_d = cnt_q + CntW'(1);
        if (expired) begin
          err_d   = 1'b1;
          dout_d  = '0;
          state_d = StDone;
        end else if (bus_rvalid) begin
          dout_d  = ctrl_q[3] ? '0 : load_val;
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and latched-access registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      ctrl_q  <= '0;
      addr_q  <= '0;
      din_q   <= '0;
      dout_q  <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      dout_q  <= dout_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  // Outputs decoded from state; bus fields are only driven while requesting.
  always_comb begin
    mem_ready = (state_q == StDone);
    mem_dout  = mem_ready ? dout_q : '0;
    mem_err   = mem_ready & err_q;
    bus_req   = (state_q == StReq);
    bus_we    = bus_req & ctrl_q[3];
    bus_be    = bus_req ? be : 4'b0000;
    bus_addr  = bus_req ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
    bus_wdata = bus_we ? wdata : '0;
  end

endmodule

// File: tb/tb_mem_bridge.sv
// Self-checking bench for mem_bridge: behavioural byte-lane model plus per-cycle monitor.
module tb_mem_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  mem_ctrl;
  logic [31:0] mem_addr, mem_din, mem_dout;
  logic        mem_ready, mem_err;
  logic        bus_req, bus_we;
  logic [3:0]  bus_be;
  logic [31:0] bus_addr, bus_wdata;
  logic        bus_gnt, bus_rvalid;
  logic [31:0] bus_rdata;

  // Second instance with a short timeout.
  logic [4:0]  t_ctrl;
  logic [31:0] t_addr, t_din, t_dout;
  logic        t_ready, t_err, t_req, t_we;
  logic [3:0]  t_be;
  logic [31:0] t_baddr, t_wdata;
  logic        t_gnt, t_rvalid;
  logic [31:0] t_rdata;

  always #5 clk = ~clk;

  mem_bridge dut (
    .clk(clk), .rst(rst), .mem_ctrl(mem_ctrl), .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_dout(mem_dout), .mem_ready(mem_ready), .mem_err(mem_err), .bus_req(bus_req),
    .bus_we(bus_we), .bus_be(bus_be), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
  );

  mem_bridge #(.TIMEOUT(8)) dut_to (
    .clk(clk), .rst(rst), .mem_ctrl(t_ctrl), .mem_addr(t_addr), .mem_din(t_din),
    .mem_dout(t_dout), .mem_ready(t_ready), .mem_err(t_err), .bus_req(t_req),
    .bus_we(t_we), .bus_be(t_be), .bus_addr(t_baddr), .bus_wdata(t_wdata),
    .bus_gnt(t_gnt), .bus_rvalid(t_rvalid), .bus_rdata(t_rdata)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int n_ready  = 0;

  // Expectations for the transaction in flight.
  logic        mon_en, txn_active;
  logic        exp_err, exp_we;
  logic [3:0]  exp_be;
  logic [31:0] exp_wdata, exp_dout, exp_baddr;
  int          t0, gdv, exp_rdy_cyc;
  logic [31:0] last_dout;
  logic        last_err;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: what one access must look like on the bus and at the core port.
  task automatic model(input logic [4:0] c, input logic [31:0] a, d, r,
                       output logic e, output logic [3:0] b,
                       output logic [31:0] w, output logic [31:0] o);
    int     sz, nb, off;
    longint v;
    sz  = int'(c[1:0]);
    off = int'(a[1:0]);
    nb  = (sz == 3) ? 4 : (1 << sz);
    e   = (sz == 3) || ((off % nb) != 0);
    b   = 4'b0000;
    w   = 32'h0;
    for (int i = 0; i < 4; i++) begin
      if (i >= off && i < off + nb) b[i] = 1'b1;
      w[8*i +: 8] = d[8*(i % nb) +: 8];
    end
    v = longint'(r >> (8 * off)) & ((longint'(1) << (8 * nb)) - 1);
    if (!c[2] && nb < 4 && v >= (longint'(1) << (8 * nb - 1))) v = v - (longint'(1) << (8 * nb));
    o = v[31:0];
  endtask

  // Per-cycle compare of the main instance against the expectations.
  always @(negedge clk) begin
    logic er, eq;
    if (mem_ready) n_ready++;
    if (mon_en && !rst) begin
      er = txn_active && (cyc == exp_rdy_cyc);
      eq = txn_active && !exp_err && (cyc >= t0) && (cyc <= t0 + gdv);
      chk("mem_ready", 32'(mem_ready), 32'(er));
      if (er) begin
        chk("mem_err", 32'(mem_err), 32'(exp_err));
        if (!exp_err && !exp_we) chk("mem_dout", mem_dout, exp_dout);
        last_dout = mem_dout;
        last_err  = mem_err;
      end else begin
        chk("idle_dout", mem_dout, 32'h0);
        chk("idle_err", 32'(mem_err), 32'h0);
      end
      chk("bus_req", 32'(bus_req), 32'(eq));
      if (eq) begin
        chk("bus_addr", bus_addr, exp_baddr);
        chk("bus_be", 32'(bus_be), 32'(exp_be));
        chk("bus_we", 32'(bus_we), 32'(exp_we));
        if (exp_we) chk("bus_wdata", bus_wdata, exp_wdata);
      end
    end
  end

  // One access: present it, then act as the bus with the given gnt/rvalid delays.
  task automatic access(input logic [4:0] c, input logic [31:0] a, d, r, input int gd, rd);
    logic        e;
    logic [3:0]  b;
    logic [31:0] w, o;
    int          rdy_before;
    model(c, a, d, r, e, b, w, o);
    exp_err = e; exp_be = b; exp_wdata = w; exp_dout = o; exp_we = c[3];
    exp_baddr  = a & 32'hFFFF_FFFC;
    rdy_before = n_ready;
    mem_ctrl = c; mem_addr = a; mem_din = d;
    @(posedge clk); #1;
    t0 = cyc; gdv = gd;
    exp_rdy_cyc = e ? t0 : t0 + gd + rd + 2;
    txn_active  = 1'b1;
    // Inputs after acceptance must be ignored.
    mem_ctrl = {1'b0, 4'($urandom)}; mem_addr = $urandom; mem_din = $urandom;
    if (!e) begin
      repeat (gd) begin @(posedge clk); #1; end
      bus_gnt = 1'b1;
      @(posedge clk); #1;
      bus_gnt = 1'b0;
      repeat (rd) begin bus_rdata = $urandom; @(posedge clk); #1; end
      bus_rvalid = 1'b1; bus_rdata = r;
      @(posedge clk); #1;
      bus_rvalid = 1'b0; bus_rdata = $urandom;
    end
    @(posedge clk); #1;
    txn_active = 1'b0;
    chk("ready_pulses", 32'(n_ready - rdy_before), 32'd1);
  endtask

  initial begin
    logic        e;
    logic [3:0]  b;
    logic [31:0] w, o;
    int          req_cnt, rdy_cnt, rdy_idx, stray;
    logic        req_at_rdy, err_at_rdy;
    logic [31:0] dout_at_rdy;

    rst = 1'b1; mon_en = 1'b0; txn_active = 1'b0;
    mem_ctrl = '0; mem_addr = '0; mem_din = '0;
    bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = '0;
    t_ctrl = '0; t_addr = '0; t_din = '0; t_gnt = 1'b0; t_rvalid = 1'b0; t_rdata = '0;
    t0 = 0; gdv = 0; exp_rdy_cyc = 0; last_dout = '0; last_err = 1'b0;
    exp_err = 1'b0; exp_we = 1'b0; exp_be = '0; exp_wdata = '0; exp_dout = '0; exp_baddr = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", 32'(mem_ready), 32'h0);
    chk("rst_err", 32'(mem_err), 32'h0);
    chk("rst_dout", mem_dout, 32'h0);
    chk("rst_req", 32'(bus_req), 32'h0);
    chk("rst_be", 32'(bus_be), 32'h0);
    chk("rst_addr", bus_addr, 32'h0);
    chk("rst_we", 32'(bus_we), 32'h0);
    chk("rst_wdata", bus_wdata, 32'h0);
    @(posedge clk); #1;
    mon_en = 1'b1;

    // Hand-computed cases pinning both model and DUT.
    model(5'b11010, 32'h100, 32'hDEADBEEF, 32'h0, e, b, w, o);
    chk("model_word_be", 32'(b), 32'hF);
    chk("model_word_wdata", w, 32'hDEADBEEF);
    access(5'b11010, 32'h100, 32'hDEADBEEF, 32'h0, 0, 0);
    chk("st_word_err", 32'(last_err), 32'h0);

    model(5'b10000, 32'h203, 32'h0, 32'h80112233, e, b, w, o);
    chk("model_sbyte_be", 32'(b), 32'h8);
    chk("model_sbyte_dout", o, 32'hFFFFFF80);
    access(5'b10000, 32'h203, 32'h0, 32'h80112233, 0, 0);
    chk("ld_sbyte", last_dout, 32'hFFFFFF80);
    access(5'b10100, 32'h203, 32'h0, 32'h80112233, 0, 0);
    chk("ld_ubyte", last_dout, 32'h00000080);

    model(5'b11001, 32'h12, 32'h0000ABCD, 32'h0, e, b, w, o);
    chk("model_half_be", 32'(b), 32'hC);
    chk("model_half_wdata", w, 32'hABCDABCD);
    access(5'b11001, 32'h12, 32'h0000ABCD, 32'h0, 0, 0);

    model(5'b10001, 32'h11, 32'h0, 32'h0, e, b, w, o);
    chk("model_misalign", 32'(e), 32'h1);
    access(5'b10001, 32'h11, 32'h0, 32'h0, 0, 0);
    chk("ld_half_misalign", 32'(last_err), 32'h1);

    access(5'b10010, 32'h80, 32'h0, 32'h12345678, 4, 3);
    chk("ld_word_slow", last_dout, 32'h12345678);

    // Randomized accesses with stray rvalids in the idle gaps.
    for (int k = 0; k < 300; k++) begin
      logic [4:0]  c;
      logic [31:0] a;
      c = {1'b1, 4'($urandom)};
      a = $urandom;
      if ($urandom_range(3) != 0) begin
        if (c[1:0] == 2'd1) a[0] = 1'b0;
        else if (c[1:0] == 2'd2) a[1:0] = 2'b00;
      end
      access(c, a, $urandom, $urandom, $urandom_range(5), $urandom_range(4));
      repeat ($urandom_range(2)) begin
        bus_rvalid = 1'($urandom_range(1)); bus_rdata = $urandom;
        @(posedge clk); #1;
      end
      bus_rvalid = 1'b0;
    end

    // Reset while waiting for the response.
    mon_en = 1'b0;
    mem_ctrl = 5'b10010; mem_addr = 32'h300;
    @(posedge clk); #1;
    mem_ctrl = '0; bus_gnt = 1'b1;
    @(posedge clk); #1;
    bus_gnt = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("wrst_ready", 32'(mem_ready), 32'h0);
    chk("wrst_err", 32'(mem_err), 32'h0);
    chk("wrst_dout", mem_dout, 32'h0);
    chk("wrst_req", 32'(bus_req), 32'h0);
    chk("wrst_be", 32'(bus_be), 32'h0);
    chk("wrst_addr", bus_addr, 32'h0);
    @(posedge clk); #1;
    mon_en = 1'b1;
    access(5'b10101, 32'h302, 32'h0, 32'hBEEF1234, 1, 1);
    chk("after_rst_ld", last_dout, 32'h0000BEEF);

    // Timeout on the short-timeout instance: gnt never comes.
    req_cnt = 0; rdy_cnt = 0; rdy_idx = -1; stray = 0;
    req_at_rdy = 1'b1; err_at_rdy = 1'b0; dout_at_rdy = 32'hFFFFFFFF;
    t_ctrl = 5'b11010; t_addr = 32'h40; t_din = 32'hCAFEF00D;
    @(posedge clk); #1;
    t_ctrl = '0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (t_req) begin
        req_cnt++;
        chk("to_addr", t_baddr, 32'h40);
        chk("to_be", 32'(t_be), 32'hF);
        chk("to_we", 32'(t_we), 32'h1);
        chk("to_wdata", t_wdata, 32'hCAFEF00D);
      end
      if (t_ready) begin
        rdy_cnt++; rdy_idx = i;
        req_at_rdy = t_req; err_at_rdy = t_err; dout_at_rdy = t_dout;
      end
    end
    chk("to_req_cycles", 32'(req_cnt), 32'd8);
    chk("to_ready_count", 32'(rdy_cnt), 32'd1);
    chk("to_ready_cycle", 32'(rdy_idx), 32'd8);
    chk("to_req_dropped", 32'(req_at_rdy), 32'h0);
    chk("to_err", 32'(err_at_rdy), 32'h1);
    chk("to_dout", dout_at_rdy, 32'h0);
    @(posedge clk); #1;
    t_rvalid = 1'b1; t_rdata = 32'h55AA55AA;
    @(posedge clk); #1;
    t_rvalid = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (t_ready) stray++;
    end
    chk("to_stray_rvalid", 32'(stray), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_bridge.md
Name: mem_bridge

Overview:
- Sits directly downstream of the core's memory port: consumes mem_ctrl/mem_addr/mem_din, returns mem_dout plus a mem_ready handshake.
- Translates each core access into one transaction on a word-wide request/grant/response bus (RAM, ROM, MMIO).
- Performs byte-lane steering for stores, sign/zero extension for loads, misalignment detection and a bus timeout.
- Replaces the fixed one-cycle memory ready with a real completion signal.

Parameters:
- TIMEOUT, 255, cycles allowed in REQ or WAIT before the access is aborted with mem_err; 0 disables the timeout.
- ADDR_W, 32, width of mem_addr and bus_addr.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- mem_ctrl  input  5  {en, we, uns, size[1:0]}; size 0=byte, 1=half, 2=word, 3=reserved
- mem_addr  input  ADDR_W  byte address from core
- mem_din  input  32  store data, right-aligned
- mem_dout  output  32  load result, extended, right-aligned
- mem_ready  output  1  one-cycle completion pulse
- mem_err  output  1  valid with mem_ready; misaligned, reserved size, or timeout
- bus_req  output  1  request valid
- bus_we  output  1  write enable
- bus_be  output  4  byte enables
- bus_addr  output  ADDR_W  word-aligned address, low 2 bits always 0
- bus_wdata  output  32  lane-steered store data
- bus_gnt  input  1  request accepted this cycle
- bus_rvalid  input  1  response valid, for reads and writes
- bus_rdata  input  32  read data

Behaviour:
- Reset values:
  - State IDLE.
  - All outputs 0, including mem_ready, mem_err, bus_req and bus_be.
  - Timeout counter 0.
  - Reset overrides everything: reset in REQ or WAIT abandons the transaction and does not wait for rvalid.
- States: IDLE, REQ, WAIT, DONE.
- IDLE:
  - If en=1, latch ctrl, addr and din.
  - Check alignment:
    - half needs addr[0]=0;
    - word needs addr[1:0]=0;
    - size 3 is always an error.
  - On error go to DONE with err=1; no bus activity.
  - Otherwise go to REQ.
- REQ:
  - bus_req=1; bus_addr, bus_we, bus_be and bus_wdata are held stable from latched values.
  - bus_gnt=1 goes to WAIT.
  - bus_req drops in the cycle after gnt is sampled.
- WAIT:
  - bus_req=0.
  - bus_rvalid=1 captures the extended read data (writes ignore rdata) and goes to DONE.
  - rvalid in the same cycle as gnt is not legal for the bus; it is ignored in REQ.
- DONE:
  - mem_ready=1 for exactly one cycle; mem_dout and mem_err valid in that cycle.
  - Next state is IDLE unconditionally.
  - en is not sampled in DONE, so there is a minimum 1-cycle gap between accesses.
  - mem_dout and mem_err return to 0 in IDLE.
- Byte enables (off = addr[1:0]):
  - byte → 1 << off
  - half → 0011 << off
  - word → 1111
- Store steering: byte din[7:0] and half din[15:0] are replicated across all lanes; bus_wdata = {4{byte}} or {2{half}}.
- Load extraction:
  - byte = rdata >> (8*off), half = rdata >> (8*off).
  - Then zero-extend if uns=1, else sign-extend.
  - Word loads pass through unchanged; uns is ignored.
- Timeout:
  - Counter clears on entering REQ.
  - Counter increments each cycle in REQ or WAIT.
  - When it reaches TIMEOUT, go to DONE with err=1 and mem_dout=0. bus_req drops immediately.
  - A late rvalid arriving in IDLE is discarded.
- Latency: minimum 3 cycles from en sampled to mem_ready (IDLE→REQ with gnt same cycle→WAIT→DONE with rvalid one cycle after gnt). A misaligned access takes 1 cycle (IDLE→DONE).
- mem_ctrl, mem_addr and mem_din changing after acceptance have no effect until the next IDLE.

Test Plan:
- Word store addr 0x100, din 0xDEADBEEF, gnt immediate, rvalid next cycle → bus_addr 0x100, be 1111, wdata 0xDEADBEEF, we=1; mem_ready pulses on cycle 3, err=0.
- Signed byte load addr 0x203, rdata 0x80112233 → be 1000, mem_dout 0xFFFFFF80; same access with uns=1 → 0x00000080.
- Half store addr 0x12, din 0x0000ABCD → bus_addr 0x10, be 1100, wdata 0xABCDABCD; half load addr 0x11 → mem_err=1, mem_ready one cycle after accept, bus_req never asserted.
- gnt withheld 4 cycles, then rvalid delayed 3 cycles → bus_req and bus_addr stable throughout REQ, exactly one mem_ready pulse, exactly one gnt handshake.
- TIMEOUT=8, gnt never asserted → bus_req high for 8 cycles then low, mem_ready with err=1 and mem_dout=0; a stray rvalid afterwards produces no ready.
- rst pulsed while in WAIT → next cycle all outputs 0 and state IDLE; a new load issued afterwards completes normally.
